// File: rtl/lbp_hist_accum.sv
// lbp_hist_accum: per-region NI/RD LBP histogram accumulator with bin-by-bin readout
// Define RIU2_MAP_EN for the 10-bin rotation-invariant uniform mapping (default: 256-bin identity).
module lbp_hist_accum #(
  parameter int N_PIXELS = 64,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [7:0]       i_ni,
  input  logic [7:0]       i_rd,
  output logic             o_ready,
  input  logic             i_flush,
  output logic             o_hist_valid,
  input  logic             i_hist_ready,
  output logic [CNT_W-1:0] o_hist_data,
  output logic             o_hist_sel,
  output logic [7:0]       o_hist_bin,
  output logic             o_hist_last
);
`ifdef RIU2_MAP_EN
  localparam int NBINS = 10;
`else
  localparam int NBINS = 256;
`endif
  typedef enum logic {ACCUM, READ} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] ni_q [NBINS];
  logic [CNT_W-1:0] rd_q [NBINS];
  logic [15:0]      cnt_q;
  logic             sel_q;
  logic [7:0]       bin_q;
  logic [7:0]       ni_bin, rd_bin;
  logic [CNT_W-1:0] hist_data;
  function automatic logic [7:0] map_bin(input logic [7:0] x);
`ifdef RIU2_MAP_EN
    // a code is uniform when its circular bit string has at most two 0/1 transitions
    return ($countones(x ^ {x[0], x[7:1]}) <= 2) ? 8'($countones(x)) : 8'd9;
`else
    return x;
`endif
  endfunction
  assign ni_bin = map_bin(i_ni);
  assign rd_bin = map_bin(i_rd);
  always_comb begin
    hist_data = '0;
    for (int b = 0; b < NBINS; b++)
      if (bin_q == 8'(b)) hist_data = sel_q ? rd_q[b] : ni_q[b];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      bin_q   <= '0;
      for (int b = 0; b < NBINS; b++) begin
        ni_q[b] <= '0;
        rd_q[b] <= '0;
      end
    end else if (i_flush) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      bin_q   <= '0;
      for (int b = 0; b < NBINS; b++) begin
        ni_q[b] <= '0;
        rd_q[b] <= '0;
      end
    end else if (state_q == ACCUM) begin
      if (i_valid) begin
        for (int b = 0; b < NBINS; b++) begin
          if (ni_bin == 8'(b) && ni_q[b] != '1) ni_q[b] <= ni_q[b] + CNT_W'(1);
          if (rd_bin == 8'(b) && rd_q[b] != '1) rd_q[b] <= rd_q[b] + CNT_W'(1);
        end
        if (cnt_q == 16'(N_PIXELS - 1)) begin
          cnt_q   <= '0;
          state_q <= READ;
          sel_q   <= 1'b0;
          bin_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end else if (i_hist_ready) begin
      for (int b = 0; b < NBINS; b++)
        if (bin_q == 8'(b)) begin
          if (sel_q) rd_q[b] <= '0;
          else ni_q[b] <= '0;
        end
      if (bin_q == 8'(NBINS - 1)) begin
        bin_q <= '0;
        sel_q <= ~sel_q;
        if (sel_q) state_q <= ACCUM;
      end else begin
        bin_q <= bin_q + 8'd1;
      end
    end
  end
  assign o_ready      = state_q == ACCUM;
  assign o_hist_valid = state_q == READ;
  assign o_hist_sel   = sel_q;
  assign o_hist_bin   = bin_q;
  assign o_hist_data  = o_hist_valid ? hist_data : '0;
  assign o_hist_last  = o_hist_valid & sel_q & (bin_q == 8'(NBINS - 1));
endmodule
